vc_arbiter_reader: RTL

- Read-side controller for the transmit-layer virtual-channel FIFOs.
- Pops packets from the VC0 and VC1 FIFOs with strict priority for VC0, and routes each packet to destination FIFO D0 or D1 using its destination bit.
- Stops popping while either destination FIFO reports almost-full.
- Sits between the VC FIFO pair and the two destination FIFOs.

---
 rtl/vc_arbiter_reader_if.sv | 36 +++
 rtl/vc_arbiter_reader.sv | 107 ++++++++++
 2 files changed

// File: rtl/vc_arbiter_reader_if.sv
// Signal bundle between the VC FIFO pair, the arbiter/reader and the two
// destination FIFOs. The master modport is the arbiter side.
interface vc_arbiter_reader_if #(
  parameter int data_width = 6,
  parameter int cnt_width  = 8
) ();
  logic                  empty_vc0;
  logic                  empty_vc1;
  logic [data_width-1:0] data_vc0;
  logic [data_width-1:0] data_vc1;
  logic                  almost_full_d0;
  logic                  almost_full_d1;
  logic                  pop_vc0;
  logic                  pop_vc1;
  logic                  push_d0;
  logic                  push_d1;
  logic [data_width-1:0] data_d0;
  logic [data_width-1:0] data_d1;
  logic [cnt_width-1:0]  pkt_cnt_d0;
  logic [cnt_width-1:0]  pkt_cnt_d1;
  logic [1:0]            state;

  modport master (
    input  empty_vc0, empty_vc1, data_vc0, data_vc1,
    input  almost_full_d0, almost_full_d1,
    output pop_vc0, pop_vc1, push_d0, push_d1,
    output data_d0, data_d1, pkt_cnt_d0, pkt_cnt_d1, state
  );

  modport slave (
    output empty_vc0, empty_vc1, data_vc0, data_vc1,
    output almost_full_d0, almost_full_d1,
    input  pop_vc0, pop_vc1, push_d0, push_d1,
    input  data_d0, data_d1, pkt_cnt_d0, pkt_cnt_d1, state
  );
endinterface

// File: rtl/vc_arbiter_reader.sv
// Read-side arbiter for the VC0/VC1 FIFOs. VC0 has strict priority; each
// popped packet is routed to D0 or D1 by its top bit, two cycles after the pop.
//
//   state  | meaning
//   IDLE   | both VC FIFOs empty, nothing popped
//   ACTIVE | popping whenever no back-pressure and a VC is non-empty
//   STALL  | a destination is almost full, popping suspended
module vc_arbiter_reader #(
  parameter int data_width = 6,
  parameter int cnt_width  = 8
) (
  input logic                clk,
  input logic                reset,
  vc_arbiter_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  bp;
  logic                  both_empty;
  logic                  pop0, pop1;
  logic                  inflight_v;
  logic                  inflight_src;   // 1: packet came from VC1
  logic [data_width-1:0] sel_data;
  logic                  push0_q, push1_q;
  logic [data_width-1:0] data0_q, data1_q;
  logic [cnt_width-1:0]  cnt0_q, cnt1_q;

  assign bp         = bus.almost_full_d0 | bus.almost_full_d1;
  assign both_empty = bus.empty_vc0 & bus.empty_vc1;
  assign sel_data   = inflight_src ? bus.data_vc1 : bus.data_vc0;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and pop decode; pops are held off while reset is asserted.
  always_comb begin
    state_d = state_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!both_empty) state_d = ACTIVE;
      end
      ACTIVE: begin
        pop0 = reset & ~bp & ~bus.empty_vc0;
        pop1 = reset & ~bp & bus.empty_vc0 & ~bus.empty_vc1;
        if (bp)              state_d = STALL;
        else if (both_empty) state_d = IDLE;
      end
      STALL: begin
        if (!bp) state_d = both_empty ? IDLE : ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop-to-push pipeline: remember the source for one cycle, then route the
  // returned packet by its destination bit and count it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight_v   <= 1'b0;
      inflight_src <= 1'b0;
      push0_q      <= 1'b0;
      push1_q      <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      inflight_v   <= pop0 | pop1;
      inflight_src <= pop1;
      push0_q      <= 1'b0;
      push1_q      <= 1'b0;
      if (inflight_v) begin
        if (sel_data[data_width-1]) begin
          push1_q <= 1'b1;
          data1_q <= sel_data;
          cnt1_q  <= cnt1_q + 1'b1;
        end else begin
          push0_q <= 1'b1;
          data0_q <= sel_data;
          cnt0_q  <= cnt0_q + 1'b1;
        end
      end
    end
  end

  assign bus.pop_vc0    = pop0;
  assign bus.pop_vc1    = pop1;
  assign bus.push_d0    = push0_q;
  assign bus.push_d1    = push1_q;
  assign bus.data_d0    = data0_q;
  assign bus.data_d1    = data1_q;
  assign bus.pkt_cnt_d0 = cnt0_q;
  assign bus.pkt_cnt_d1 = cnt1_q;
  assign bus.state      = state_q;

endmodule
